// File: rtl/noc_local_injector.sv
// noc_local_injector: serialises a nibble-chunked message into XY-headed
// flits for the router's local input port, with a bubble after each flit.
module noc_local_injector #(
    parameter int WIDTH         = 8,
    parameter int PAYLOAD_WIDTH = 16,
    parameter int GAP_CYCLES    = 1,
    parameter int LEN_W         = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     msg_valid,
    output logic                     msg_ready,
    input  logic [1:0]               msg_dest_x,
    input  logic [1:0]               msg_dest_y,
    input  logic [PAYLOAD_WIDTH-1:0] msg_payload,
    input  logic [LEN_W-1:0]         msg_len,
    output logic [WIDTH-1:0]         flit_data,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic                     busy,
    output logic [15:0]              sent_count
);

    localparam int CHUNKS = PAYLOAD_WIDTH / 4;
    // Counter only has to hold GAP_CYCLES-1
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] CHUNKS_L = LEN_W'(CHUNKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               dx_q, dx_d;
    logic [1:0]               dy_q, dy_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         idx_q, idx_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [15:0]              sent_q, sent_d;

    logic [LEN_W-1:0]         len_eff;
    logic                     last;
    logic [PAYLOAD_WIDTH-1:0] shifted;

    assign len_eff = (msg_len > CHUNKS_L) ? CHUNKS_L : msg_len;
    // idx counts flits already sent, so the last one is at idx == len-1
    assign last    = ((idx_q + LEN_W'(1)) == len_q);
    assign shifted = payload_q >> {idx_q, 2'b00};

    // Outputs decode the registered state and captured message only
    assign msg_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign flit_valid = (state_q == SEND);
    assign flit_data  = (state_q == SEND)
                      ? WIDTH'({dx_q, dy_q, shifted[3:0]})
                      : '0;
    assign sent_count = sent_q;

    // Next-state and datapath update for IDLE -> SEND <-> GAP sequencing
    always_comb begin
        state_d   = state_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        payload_d = payload_q;
        len_d     = len_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        sent_d    = sent_q;
        unique case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    dx_d      = msg_dest_x;
                    dy_d      = msg_dest_y;
                    payload_d = msg_payload;
                    len_d     = len_eff;
                    idx_d     = '0;
                    if (len_eff != '0) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (flit_ready) begin
                    sent_d = sent_q + 16'd1;
                    idx_d  = idx_q + LEN_W'(1);
                    gap_d  = GAP_LOAD;
                    if (GAP_CYCLES != 0) begin
                        state_d = GAP;
                    end else if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = (idx_q == len_q) ? IDLE : SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-message registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dx_q      <= '0;
            dy_q      <= '0;
            payload_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            payload_q <= payload_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
        end
    end

endmodule

// File: tb/tb_noc_local_injector.sv
// tb_noc_local_injector: scoreboard bench for the local injector, with a
// small stale-ready buffer model and a gapless instance for count wrap.
module tb_noc_local_injector;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_dest_x;
    logic [1:0]  msg_dest_y;
    logic [15:0] msg_payload;
    logic [2:0]  msg_len;
    logic [7:0]  flit_data;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;
    logic [15:0] sent_count;

    logic        rdy_drv;
    logic        rdy_mode;
    logic        model_rdy;
    logic        drain;
    int          fcnt;

    logic        w_valid;
    logic        w_mrdy;
    logic [27:0] w_payload;
    logic [2:0]  w_len;
    logic [7:0]  w_data;
    logic        w_fvalid;
    logic        w_busy;
    logic [15:0] w_sent;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_sent = 0;
    logic [7:0]  sb[$];

    assign flit_ready = rdy_mode ? model_rdy : rdy_drv;

    noc_local_injector #(
        .WIDTH(8), .PAYLOAD_WIDTH(16), .GAP_CYCLES(1), .LEN_W(3)
    ) u_dut (
        .clk(clk), .rst(rst),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_dest_x(msg_dest_x), .msg_dest_y(msg_dest_y),
        .msg_payload(msg_payload), .msg_len(msg_len),
        .flit_data(flit_data), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .busy(busy),
        .sent_count(sent_count)
    );

    noc_local_injector #(
        .WIDTH(8), .PAYLOAD_WIDTH(28), .GAP_CYCLES(0), .LEN_W(3)
    ) u_wrap (
        .clk(clk), .rst(rst),
        .msg_valid(w_valid), .msg_ready(w_mrdy),
        .msg_dest_x(2'd3), .msg_dest_y(2'd0),
        .msg_payload(w_payload), .msg_len(w_len),
        .flit_data(w_data), .flit_valid(w_fvalid),
        .flit_ready(1'b1), .busy(w_busy),
        .sent_count(w_sent)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Router buffer model: ready registered from the pre-write count
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt      <= 0;
            model_rdy <= 1'b1;
        end else if (rdy_mode) begin
            fcnt <= fcnt + int'(flit_valid && flit_ready)
                         - int'(drain && fcnt > 0);
            model_rdy <= (fcnt < DEPTH);
        end
    end

    // Flit monitor: a transfer seen here completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && flit_valid && flit_ready) begin
            if (sb.size() == 0) chk("unexp_flit", 32'(sb.size()), 1);
            else chk("flit", flit_data, sb.pop_front());
            if (rdy_mode) chk("room", fcnt < DEPTH, 1);
            exp_sent = (exp_sent + 1) & 16'hFFFF;
        end
    end

    task automatic send_msg(input logic [1:0] x, input logic [1:0] y,
                            input logic [15:0] p, input logic [2:0] len);
        int l;
        l = (len > 3'd4) ? 4 : int'(len);
        for (int i = 0; i < l; i++) sb.push_back({x, y, p[4*i +: 4]});
        @(posedge clk); #1;
        msg_dest_x  = x;
        msg_dest_y  = y;
        msg_payload = p;
        msg_len     = len;
        msg_valid   = 1'b1;
        @(negedge clk);
        chk("acc_rdy", msg_ready, 1);
        @(posedge clk); #1;
        msg_valid   = 1'b0;
        msg_payload = 16'($urandom);
        msg_dest_x  = 2'($urandom);
        msg_dest_y  = 2'($urandom);
        msg_len     = 3'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (msg_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_idle"}, ok, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        int         acc;
        logic [7:0] wexp [3];
        wexp = '{8'hCC, 8'hCB, 8'hCA};
        rst = 1'b1;
        msg_valid = 1'b0; msg_dest_x = '0; msg_dest_y = '0;
        msg_payload = '0; msg_len = '0;
        rdy_drv = 1'b1; rdy_mode = 1'b0; drain = 1'b0;
        w_valid = 1'b0; w_payload = 28'h0000ABC; w_len = 3'd7;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", flit_valid, 0);
        chk("rst_data", flit_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mrdy", msg_ready, 1);
        chk("rst_sent", sent_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic send and one-in-two valid pattern
        send_msg(2'd2, 2'd1, 16'hBEEF, 3'd4);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t1_valid", flit_valid, (i < 8) && (i % 2 == 0));
            chk("t1_mrdy", msg_ready, i == 8);
        end
        chk("t1_sent", sent_count, 4);
        chk("t1_sb", sb.size(), 0);

        // Backpressure on the second flit
        send_msg(2'd2, 2'd1, 16'hBEEF, 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy_drv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_v", flit_valid, 1);
            chk("t2_hold_d", flit_data, 8'h9E);
        end
        @(posedge clk); #1;
        rdy_drv = 1'b1;
        wait_idle("t2", 40);
        chk("t2_sent", sent_count, 8);
        chk("t2_sb", sb.size(), 0);

        // Length limits
        send_msg(2'd1, 2'd2, 16'h1234, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_len0_v", flit_valid, 0);
            chk("t3_len0_r", msg_ready, 1);
        end
        chk("t3_len0_sent", sent_count, 8);
        send_msg(2'd3, 2'd3, 16'hA5C3, 3'd7);
        wait_idle("t3", 40);
        chk("t3_len7_sent", sent_count, 12);
        chk("t3_sb", sb.size(), 0);

        // Stale-ready buffer: fills, stalls, then drains in order
        rdy_mode = 1'b1;
        send_msg(2'd1, 2'd1, 16'h4321, 3'd4);
        repeat (12) @(negedge clk);
        chk("t4_stall_sent", sent_count, 14);
        chk("t4_stall_v", flit_valid, 1);
        chk("t4_stall_r", flit_ready, 0);
        chk("t4_stall_busy", busy, 1);
        @(posedge clk); #1;
        drain = 1'b1;
        wait_idle("t4", 60);
        chk("t4_sent", sent_count, 16);
        chk("t4_sb", sb.size(), 0);
        @(posedge clk); #1;
        rdy_mode = 1'b0;
        drain = 1'b0;

        // Asynchronous reset mid-message
        send_msg(2'd2, 2'd1, 16'hBEEF, 3'd4);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sent_count == 16'd18) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_two_sent", ok, 1);
        @(negedge clk);
        chk("t5_pre_v", flit_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_v", flit_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_mrdy", msg_ready, 1);
        chk("t5_sent", sent_count, 0);
        chk("t5_data", flit_data, 0);
        sb.delete();
        exp_sent = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_msg(2'd0, 2'd3, 16'h7A51, 3'd3);
        wait_idle("t5", 40);
        chk("t5_after_sent", sent_count, 3);
        chk("t5_exp_sent", sent_count, 16'(exp_sent));
        chk("t5_sb", sb.size(), 0);

        // Wrap on the gapless instance: 9362 x 7 = 0xFFFE flits
        @(posedge clk); #1;
        w_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 80000; n++) begin
            @(negedge clk);
            if (w_valid && w_mrdy) acc++;
            if (acc == 9362) break;
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
        chk("t6_msgs", acc, 9362);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (w_mrdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_idle", ok, 1);
        chk("t6_pre", w_sent, 16'hFFFE);
        @(posedge clk); #1;
        w_len = 3'd3;
        w_valid = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_wv", w_fvalid, 1);
            chk("t6_wd", w_data, wexp[i]);
        end
        @(negedge clk);
        chk("t6_wrdy", w_mrdy, 1);
        chk("t6_wrap", w_sent, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
